// File: rtl/l2_data_server_pkg.sv
// Shared definitions for the L2 cache stages.
// Holds the data-server FSM state encoding, the latency counter width and
// the default latency / depth / width constants, plus a helper that turns a
// latency in cycles into the value loaded into the down-counter.
package l2_data_server_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2,
        ST_RD_RESP = 2'd3
    } l2_state_e;

    localparam int L2_LAT_CNT_WIDTH         = 4;
    localparam int L2_DEFAULT_LATENCY       = 4;
    localparam int L2_DEFAULT_DEPTH_LOG2    = 10;
    localparam int L2_DEFAULT_ADDRESS_WIDTH = 32;
    localparam int L2_DEFAULT_BUS_WIDTH     = 32;

    // The counter expires at zero, so a latency of N cycles loads N-1.
    function automatic logic [L2_LAT_CNT_WIDTH-1:0] latency_load(input int latency);
        return L2_LAT_CNT_WIDTH'(latency - 1);
    endfunction

endpackage

// File: rtl/l2_data_server_ram.sv
// L2 data storage: single-port word array, synchronous write, combinational
// read. Contents are never reset.
// Ports:
//   CLK      - clock, write on rising edge
//   wr_en    - write strobe
//   addr     - word index (shared by read and write)
//   wr_data  - write word
//   rd_data  - word currently stored at addr
module l2_data_server_ram
    import l2_data_server_pkg::*;
#(
    parameter int DATA_WIDTH = L2_DEFAULT_BUS_WIDTH,
    parameter int DEPTH_LOG2 = L2_DEFAULT_DEPTH_LOG2
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_reg[addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[addr];

endmodule

// File: rtl/l2_data_server.sv
// L2 data server: serves one word write or word read at a time with a fixed
// access latency. Writes take priority over reads presented in the same
// cycle. Read data is held in RD_RESP until the requester accepts it.
// Ports:
//   CLK, RST                          - clock, async active-high reset
//   WRITE_TO_L2_VALID/READY_DATA      - write request handshake
//   WRITE_ADDR_TO_L2_DATA             - write word address
//   DATA_TO_L2_DATA                   - write data
//   WRITE_CONTROL_TO_L2_DATA          - 1 commits the write, 0 handshake only
//   WRITE_COMPLETE_DATA               - one-cycle pulse when a write retires
//   READ_ADDR_TO_L2_VALID/READY_DATA  - read request handshake
//   READ_ADDR_TO_L2_DATA              - read word address
//   DATA_FROM_L2_VALID/READY_DATA     - read response handshake
//   DATA_FROM_L2_DATA                 - read data, zero while not valid
module l2_data_server
    import l2_data_server_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = L2_DEFAULT_ADDRESS_WIDTH,
    parameter int L2_BUS_WIDTH   = L2_DEFAULT_BUS_WIDTH,
    parameter int MEM_DEPTH_LOG2 = L2_DEFAULT_DEPTH_LOG2,
    parameter int ACCESS_LATENCY = L2_DEFAULT_LATENCY
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WRITE_TO_L2_VALID_DATA,
    output logic                     WRITE_TO_L2_READY_DATA,
    input  logic [ADDRESS_WIDTH-3:0] WRITE_ADDR_TO_L2_DATA,
    input  logic [L2_BUS_WIDTH-1:0]  DATA_TO_L2_DATA,
    input  logic                     WRITE_CONTROL_TO_L2_DATA,
    output logic                     WRITE_COMPLETE_DATA,
    input  logic                     READ_ADDR_TO_L2_VALID_DATA,
    output logic                     READ_ADDR_TO_L2_READY_DATA,
    input  logic [ADDRESS_WIDTH-3:0] READ_ADDR_TO_L2_DATA,
    output logic                     DATA_FROM_L2_VALID_DATA,
    input  logic                     DATA_FROM_L2_READY_DATA,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DATA
);

    l2_state_e                    state_reg, state_next;
    logic [L2_LAT_CNT_WIDTH-1:0]  count_reg, count_next;
    logic [ADDRESS_WIDTH-3:0]     addr_reg, addr_next;
    logic [L2_BUS_WIDTH-1:0]      wdata_reg, wdata_next;
    logic                         wctrl_reg, wctrl_next;
    logic                         wr_complete_reg, wr_complete_next;
    logic                         rd_valid_reg, rd_valid_next;
    logic [L2_BUS_WIDTH-1:0]      rd_data_reg, rd_data_next;
    logic                         ram_we;
    logic [L2_BUS_WIDTH-1:0]      ram_rd_data;

    // Only the low MEM_DEPTH_LOG2 bits index storage; upper bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_reg;

    l2_data_server_ram #(
        .DATA_WIDTH (L2_BUS_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (ram_we),
        .addr    (addr_reg[MEM_DEPTH_LOG2-1:0]),
        .wr_data (wdata_reg),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wctrl_reg       <= 1'b0;
            wr_complete_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            wctrl_reg       <= wctrl_next;
            wr_complete_reg <= wr_complete_next;
            rd_valid_reg    <= rd_valid_next;
            rd_data_reg     <= rd_data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        wctrl_next       = wctrl_reg;
        wr_complete_next = 1'b0;
        rd_valid_next    = rd_valid_reg;
        rd_data_next     = rd_data_reg;
        ram_we           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Write checked first: a pending write masks read ready.
                if (WRITE_TO_L2_VALID_DATA) begin
                    state_next = ST_WR_BUSY;
                    count_next = latency_load(ACCESS_LATENCY);
                    addr_next  = WRITE_ADDR_TO_L2_DATA;
                    wdata_next = DATA_TO_L2_DATA;
                    wctrl_next = WRITE_CONTROL_TO_L2_DATA;
                end else if (READ_ADDR_TO_L2_VALID_DATA) begin
                    state_next = ST_RD_BUSY;
                    count_next = latency_load(ACCESS_LATENCY);
                    addr_next  = READ_ADDR_TO_L2_DATA;
                end
            end
            ST_WR_BUSY: begin
                if (count_reg == '0) begin
                    ram_we           = wctrl_reg;
                    wr_complete_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            ST_RD_BUSY: begin
                if (count_reg == '0) begin
                    rd_valid_next = 1'b1;
                    rd_data_next  = ram_rd_data;
                    state_next    = ST_RD_RESP;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            ST_RD_RESP: begin
                // Data register is cleared with valid so the bus reads zero
                // whenever no response is presented.
                if (DATA_FROM_L2_READY_DATA) begin
                    rd_valid_next = 1'b0;
                    rd_data_next  = '0;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign WRITE_TO_L2_READY_DATA     = (state_reg == ST_IDLE);
    assign READ_ADDR_TO_L2_READY_DATA = (state_reg == ST_IDLE) && !WRITE_TO_L2_VALID_DATA;
    assign WRITE_COMPLETE_DATA        = wr_complete_reg;
    assign DATA_FROM_L2_VALID_DATA    = rd_valid_reg;
    assign DATA_FROM_L2_DATA          = rd_data_reg;

endmodule

// File: tb/tb_l2_data_server.sv
// Self-checking bench for l2_data_server: directed scenarios plus a random
// write/read mix checked against a word-array reference memory.
module tb_l2_data_server;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DL2 = 10;
    localparam int LAT = 4;

    logic            CLK;
    logic            RST;
    logic            WRITE_TO_L2_VALID_DATA;
    logic            WRITE_TO_L2_READY_DATA;
    logic [AW-3:0]   WRITE_ADDR_TO_L2_DATA;
    logic [DW-1:0]   DATA_TO_L2_DATA;
    logic            WRITE_CONTROL_TO_L2_DATA;
    logic            WRITE_COMPLETE_DATA;
    logic            READ_ADDR_TO_L2_VALID_DATA;
    logic            READ_ADDR_TO_L2_READY_DATA;
    logic [AW-3:0]   READ_ADDR_TO_L2_DATA;
    logic            DATA_FROM_L2_VALID_DATA;
    logic            DATA_FROM_L2_READY_DATA;
    logic [DW-1:0]   DATA_FROM_L2_DATA;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [0:(1<<DL2)-1];
    int            known_q[$];

    l2_data_server #(
        .ADDRESS_WIDTH  (AW),
        .L2_BUS_WIDTH   (DW),
        .MEM_DEPTH_LOG2 (DL2),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .WRITE_TO_L2_VALID_DATA     (WRITE_TO_L2_VALID_DATA),
        .WRITE_TO_L2_READY_DATA     (WRITE_TO_L2_READY_DATA),
        .WRITE_ADDR_TO_L2_DATA      (WRITE_ADDR_TO_L2_DATA),
        .DATA_TO_L2_DATA            (DATA_TO_L2_DATA),
        .WRITE_CONTROL_TO_L2_DATA   (WRITE_CONTROL_TO_L2_DATA),
        .WRITE_COMPLETE_DATA        (WRITE_COMPLETE_DATA),
        .READ_ADDR_TO_L2_VALID_DATA (READ_ADDR_TO_L2_VALID_DATA),
        .READ_ADDR_TO_L2_READY_DATA (READ_ADDR_TO_L2_READY_DATA),
        .READ_ADDR_TO_L2_DATA       (READ_ADDR_TO_L2_DATA),
        .DATA_FROM_L2_VALID_DATA    (DATA_FROM_L2_VALID_DATA),
        .DATA_FROM_L2_READY_DATA    (DATA_FROM_L2_READY_DATA),
        .DATA_FROM_L2_DATA          (DATA_FROM_L2_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference memory: word index is the low DL2 address bits.
    function automatic int idx_of(input logic [AW-3:0] a);
        return int'(a[DL2-1:0]);
    endfunction

    task automatic model_write(input logic [AW-3:0] a, input logic [DW-1:0] d, input logic c);
        if (c) begin
            if (!(idx_of(a) inside {known_q})) known_q.push_back(idx_of(a));
            model_mem[idx_of(a)] = d;
        end
    endtask

    // Issue a write at posedge+1 alignment; returns cycles from accept edge to
    // the first sample showing the complete pulse, the number of busy samples
    // with ready low, and the pulse width in cycles.
    task automatic drive_write(input logic [AW-3:0] a, input logic [DW-1:0] d, input logic c,
                               output int lat, output int busy_low, output int pulse_w,
                               output logic ready_start);
        WRITE_ADDR_TO_L2_DATA    = a;
        DATA_TO_L2_DATA          = d;
        WRITE_CONTROL_TO_L2_DATA = c;
        WRITE_TO_L2_VALID_DATA   = 1'b1;
        ready_start = WRITE_TO_L2_READY_DATA;
        @(posedge CLK); #1;
        WRITE_TO_L2_VALID_DATA = 1'b0;
        lat = -1; busy_low = 0; pulse_w = 0;
        for (int k = 0; k < 20; k++) begin
            if (!WRITE_TO_L2_READY_DATA) busy_low++;
            if (WRITE_COMPLETE_DATA) begin lat = k; break; end
            @(posedge CLK); #1;
        end
        if (lat >= 0) begin
            pulse_w = 1;
            for (int j = 0; j < 5; j++) begin
                @(posedge CLK); #1;
                if (WRITE_COMPLETE_DATA) pulse_w++;
                else break;
            end
        end
        $display("wr addr=%h data=%h ctrl=%0d lat=%0d", a, d, c, lat);
    endtask

    // Issue a read; response ready is held low for 'hold' cycles after valid.
    task automatic drive_read(input logic [AW-3:0] a, input int hold,
                              output int lat, output logic [DW-1:0] data,
                              output int stable, output int blocked,
                              output logic valid_after, output logic [DW-1:0] data_after);
        READ_ADDR_TO_L2_DATA       = a;
        READ_ADDR_TO_L2_VALID_DATA = 1'b1;
        DATA_FROM_L2_READY_DATA    = (hold == 0);
        @(posedge CLK); #1;
        READ_ADDR_TO_L2_VALID_DATA = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (DATA_FROM_L2_VALID_DATA) begin lat = k; break; end
            @(posedge CLK); #1;
        end
        data = DATA_FROM_L2_DATA;
        stable = 0; blocked = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            if (DATA_FROM_L2_VALID_DATA && DATA_FROM_L2_DATA === data) stable++;
            if (!WRITE_TO_L2_READY_DATA && !READ_ADDR_TO_L2_READY_DATA) blocked++;
        end
        DATA_FROM_L2_READY_DATA = 1'b1;
        @(posedge CLK); #1;
        valid_after = DATA_FROM_L2_VALID_DATA;
        data_after  = DATA_FROM_L2_DATA;
        DATA_FROM_L2_READY_DATA = 1'b0;
        $display("rd addr=%h data=%h lat=%0d hold=%0d", a, data, lat, hold);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++; if (WRITE_COMPLETE_DATA !== 1'b0) begin errors++; $display("FAIL reset_complete got=%b exp=0", WRITE_COMPLETE_DATA); end
        checks++; if (DATA_FROM_L2_VALID_DATA !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", DATA_FROM_L2_VALID_DATA); end
        checks++; if (DATA_FROM_L2_DATA !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", DATA_FROM_L2_DATA); end
        checks++; if (WRITE_TO_L2_READY_DATA !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", WRITE_TO_L2_READY_DATA); end
        checks++; if (READ_ADDR_TO_L2_READY_DATA !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got=%b exp=1", READ_ADDR_TO_L2_READY_DATA); end
        repeat (2) @(posedge CLK);
        #1; RST = 1'b0;
        $display("reset released");
    endtask

    task automatic test_write_then_read();
        int lat, busy, pw, st, bl;
        logic rs, va;
        logic [DW-1:0] d, da;
        drive_write(30'h5, 32'hDEADBEEF, 1'b1, lat, busy, pw, rs);
        model_write(30'h5, 32'hDEADBEEF, 1'b1);
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL wr_ready_idle got=%b exp=1", rs); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (busy !== LAT) begin errors++; $display("FAIL wr_ready_low got=%0d exp=%0d", busy, LAT); end
        checks++; if (pw !== 1) begin errors++; $display("FAIL wr_pulse_width got=%0d exp=1", pw); end
        drive_read(30'h5, 0, lat, d, st, bl, va, da);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got=%b exp=0", va); end
        checks++; if (da !== '0) begin errors++; $display("FAIL rd_data_zero got=%h exp=0", da); end
    endtask

    task automatic test_backpressure();
        int lat, st, bl;
        logic va;
        logic [DW-1:0] d, da;
        drive_read(30'h5, 3, lat, d, st, bl, va, da);
        checks++; if (d !== model_mem[5]) begin errors++; $display("FAIL bp_data got=%h exp=%h", d, model_mem[5]); end
        checks++; if (st !== 3) begin errors++; $display("FAIL bp_stable got=%0d exp=3", st); end
        checks++; if (bl !== 3) begin errors++; $display("FAIL bp_blocked got=%0d exp=3", bl); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%b exp=0", va); end
    endtask

    task automatic test_simultaneous();
        int wr_k, rd_k;
        logic rd_blocked, acc_pending;
        logic [DW-1:0] d;
        WRITE_ADDR_TO_L2_DATA      = 30'h7;
        DATA_TO_L2_DATA            = 32'h11111111;
        WRITE_CONTROL_TO_L2_DATA   = 1'b1;
        WRITE_TO_L2_VALID_DATA     = 1'b1;
        READ_ADDR_TO_L2_DATA       = 30'h7;
        READ_ADDR_TO_L2_VALID_DATA = 1'b1;
        DATA_FROM_L2_READY_DATA    = 1'b1;
        #1;
        rd_blocked = !READ_ADDR_TO_L2_READY_DATA;
        @(posedge CLK); #1;
        WRITE_TO_L2_VALID_DATA = 1'b0;
        model_write(30'h7, 32'h11111111, 1'b1);
        wr_k = -1; rd_k = -1; d = '0; acc_pending = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (WRITE_COMPLETE_DATA && wr_k < 0) wr_k = k;
            if (DATA_FROM_L2_VALID_DATA) begin rd_k = k; d = DATA_FROM_L2_DATA; break; end
            acc_pending = READ_ADDR_TO_L2_VALID_DATA && READ_ADDR_TO_L2_READY_DATA;
            @(posedge CLK); #1;
            if (acc_pending) READ_ADDR_TO_L2_VALID_DATA = 1'b0;
        end
        READ_ADDR_TO_L2_VALID_DATA = 1'b0;
        @(posedge CLK); #1;
        DATA_FROM_L2_READY_DATA = 1'b0;
        $display("sim wr+rd addr=7 wr_lat=%0d rd_at=%0d data=%h", wr_k, rd_k, d);
        checks++; if (rd_blocked !== 1'b1) begin errors++; $display("FAIL sim_rd_held got=%b exp=1", rd_blocked); end
        checks++; if (wr_k !== LAT) begin errors++; $display("FAIL sim_wr_latency got=%0d exp=%0d", wr_k, LAT); end
        checks++; if (rd_k !== 2*LAT+1) begin errors++; $display("FAIL sim_rd_time got=%0d exp=%0d", rd_k, 2*LAT+1); end
        checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL sim_rd_data got=%h exp=11111111", d); end
        checks++; if (DATA_FROM_L2_VALID_DATA !== 1'b0) begin errors++; $display("FAIL sim_valid_drop got=%b exp=0", DATA_FROM_L2_VALID_DATA); end
    endtask

    task automatic test_alias_and_ctrl0();
        int lat, busy, pw, st, bl;
        logic rs, va;
        logic [DW-1:0] d, da;
        drive_write(30'h403, 32'hA5A5A5A5, 1'b1, lat, busy, pw, rs);
        model_write(30'h403, 32'hA5A5A5A5, 1'b1);
        drive_read(30'h3, 0, lat, d, st, bl, va, da);
        checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_data got=%h exp=a5a5a5a5", d); end
        drive_write(30'h3, 32'h5A5A5A5A, 1'b0, lat, busy, pw, rs);
        model_write(30'h3, 32'h5A5A5A5A, 1'b0);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ctrl0_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (pw !== 1) begin errors++; $display("FAIL ctrl0_pulse got=%0d exp=1", pw); end
        drive_read(30'h3, 1, lat, d, st, bl, va, da);
        checks++; if (d !== model_mem[3]) begin errors++; $display("FAIL ctrl0_unchanged got=%h exp=%h", d, model_mem[3]); end
    endtask

    task automatic test_reset_mid();
        int lat, busy, pw, st, bl, pulses;
        logic rs, va;
        logic [DW-1:0] d, da;
        drive_write(30'h9, 32'h12345678, 1'b1, lat, busy, pw, rs);
        model_write(30'h9, 32'h12345678, 1'b1);
        WRITE_ADDR_TO_L2_DATA    = 30'h9;
        DATA_TO_L2_DATA          = 32'hFFFF0000;
        WRITE_CONTROL_TO_L2_DATA = 1'b1;
        WRITE_TO_L2_VALID_DATA   = 1'b1;
        @(posedge CLK); #1;
        WRITE_TO_L2_VALID_DATA = 1'b0;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b1;
        #1;
        checks++; if (WRITE_TO_L2_READY_DATA !== 1'b1) begin errors++; $display("FAIL midrst_wr_ready got=%b exp=1", WRITE_TO_L2_READY_DATA); end
        checks++; if (READ_ADDR_TO_L2_READY_DATA !== 1'b1) begin errors++; $display("FAIL midrst_rd_ready got=%b exp=1", READ_ADDR_TO_L2_READY_DATA); end
        @(posedge CLK); #1;
        RST = 1'b0;
        pulses = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            if (WRITE_COMPLETE_DATA) pulses++;
            @(posedge CLK); #1;
        end
        $display("midrst aborted write addr=9 pulses=%0d", pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
        drive_read(30'h9, 0, lat, d, st, bl, va, da);
        checks++; if (d !== model_mem[9]) begin errors++; $display("FAIL midrst_retained got=%h exp=%h", d, model_mem[9]); end
    endtask

    task automatic test_random();
        int lat, busy, pw, st, bl, hold, idx;
        logic rs, va, c;
        logic [DW-1:0] d, da, wd;
        logic [AW-3:0] a;
        for (int n = 0; n < 40; n++) begin
            if (known_q.size() > 0 && ($urandom % 2) == 1) begin
                idx  = known_q[$urandom_range(0, known_q.size() - 1)];
                a    = AW'(idx) | (AW'($urandom_range(0, 3)) << DL2);
                hold = $urandom_range(0, 2);
                drive_read(a, hold, lat, d, st, bl, va, da);
                checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd_rd_latency n=%0d got=%0d exp=%0d", n, lat, LAT); end
                checks++; if (d !== model_mem[idx]) begin errors++; $display("FAIL rnd_rd_data n=%0d got=%h exp=%h", n, d, model_mem[idx]); end
                checks++; if (st !== hold) begin errors++; $display("FAIL rnd_rd_stable n=%0d got=%0d exp=%0d", n, st, hold); end
                checks++; if (va !== 1'b0 || da !== '0) begin errors++; $display("FAIL rnd_rd_drop n=%0d got=%b/%h exp=0/0", n, va, da); end
            end else begin
                a  = AW'($urandom_range(0, 31)) | (AW'($urandom_range(0, 3)) << DL2);
                wd = $urandom;
                c  = (($urandom % 4) != 0);
                drive_write(a, wd, c, lat, busy, pw, rs);
                model_write(a, wd, c);
                checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd_wr_latency n=%0d got=%0d exp=%0d", n, lat, LAT); end
                checks++; if (pw !== 1) begin errors++; $display("FAIL rnd_wr_pulse n=%0d got=%0d exp=1", n, pw); end
            end
        end
    endtask

    initial begin
        RST                        = 1'b1;
        WRITE_TO_L2_VALID_DATA     = 1'b0;
        WRITE_ADDR_TO_L2_DATA      = '0;
        DATA_TO_L2_DATA            = '0;
        WRITE_CONTROL_TO_L2_DATA   = 1'b0;
        READ_ADDR_TO_L2_VALID_DATA = 1'b0;
        READ_ADDR_TO_L2_DATA       = '0;
        DATA_FROM_L2_READY_DATA    = 1'b0;
        @(posedge CLK);
        test_reset();
        test_write_then_read();
        test_backpressure();
        test_simultaneous();
        test_alias_and_ctrl0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_data_server.md
L2_DATA_SERVER -- requirements
Module: L2_DATA_SERVER

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 32, byte-address width; L2_BUS_WIDTH, default 32, data word width; MEM_DEPTH_LOG2, default 10, log2 of words stored; ACCESS_LATENCY, default 4, cycles from accept to completion (legal range 1..15).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 WRITE_TO_L2_VALID_DATA  in  1  write request valid.
REQ-005 WRITE_TO_L2_READY_DATA  out  1  write request may be accepted.
REQ-006 WRITE_ADDR_TO_L2_DATA  in  ADDRESS_WIDTH-2  write word address.
REQ-007 DATA_TO_L2_DATA  in  L2_BUS_WIDTH  write data.
REQ-008 WRITE_CONTROL_TO_L2_DATA  in  1  1 = commit write to storage; 0 = handshake only, no update.
REQ-009 WRITE_COMPLETE_DATA  out  1  one-cycle pulse when an accepted write retires.
REQ-010 READ_ADDR_TO_L2_VALID_DATA  in  1  read request valid.
REQ-011 READ_ADDR_TO_L2_READY_DATA  out  1  read request may be accepted.
REQ-012 READ_ADDR_TO_L2_DATA  in  ADDRESS_WIDTH-2  read word address.
REQ-013 DATA_FROM_L2_VALID_DATA  out  1  read data valid.
REQ-014 DATA_FROM_L2_READY_DATA  in  1  requester accepts read data.
REQ-015 DATA_FROM_L2_DATA  out  L2_BUS_WIDTH  read data.

Function
REQ-016 The FSM SHALL have states IDLE, WR_BUSY, RD_BUSY, RD_RESP; one request is in service at a time.
REQ-017 WRITE_TO_L2_READY_DATA SHALL equal (state==IDLE); READ_ADDR_TO_L2_READY_DATA SHALL equal (state==IDLE) AND NOT WRITE_TO_L2_VALID_DATA.
REQ-018 A handshake SHALL occur on a rising edge with valid and ready both high; address, data and control are captured at that edge.
REQ-019 Simultaneous write and read valid in IDLE: write accepted, read held off until the FSM returns to IDLE.
REQ-020 On accept, a 4-bit latency counter SHALL load ACCESS_LATENCY-1 and decrement once per cycle in WR_BUSY/RD_BUSY.
REQ-021 WR_BUSY with counter==0: storage written at the index if control==1; WRITE_COMPLETE_DATA high for exactly the following cycle; next state IDLE.
REQ-022 RD_BUSY with counter==0: storage word latched into the output data register; DATA_FROM_L2_VALID_DATA asserted; next state RD_RESP.
REQ-023 RD_RESP SHALL hold valid and data stable until DATA_FROM_L2_READY_DATA is sampled high, then clear valid and go to IDLE.
REQ-024 DATA_FROM_L2_DATA SHALL be zero whenever DATA_FROM_L2_VALID_DATA is low.
REQ-025 Index SHALL be address bits [MEM_DEPTH_LOG2-1:0]; upper bits ignored (aliasing wrap-around).
REQ-026 Completion SHALL occur exactly ACCESS_LATENCY cycles after the accept edge; a read issued after WRITE_COMPLETE_DATA returns the new data.

Reset
REQ-027 RST high SHALL immediately force state IDLE, counter 0, WRITE_COMPLETE_DATA 0, DATA_FROM_L2_VALID_DATA 0, output data 0, captured address/data 0.
REQ-028 Reset mid-operation SHALL abort the request: no storage write, no complete pulse, no read response.
REQ-029 Storage contents SHALL NOT be reset.

Structure
REQ-030 State encodings and the default latency/depth constants SHALL reside in the shared package used by the cache stages.
REQ-031 Storage SHALL be a sub-module L2_DATA_RAM (single-port, synchronous write, combinational read, depth 2^MEM_DEPTH_LOG2).

Verification
REQ-032 Write addr 0x0000_0005, data 0xDEADBEEF, control 1, accept at edge N -> WRITE_COMPLETE_DATA high one cycle after edge N+4; ready low edges N+1..N+4.
REQ-033 Then read addr 0x5, ready held high -> DATA_FROM_L2_VALID_DATA with 0xDEADBEEF after accept+4 edges, deasserted next cycle.
REQ-034 Read with DATA_FROM_L2_READY_DATA low 3 cycles -> valid and data stable 3+ cycles; no new request accepted meanwhile.
REQ-035 Write (addr 0x7, 0x11111111) and read (addr 0x7) valid same cycle -> write first; read then returns 0x11111111.
REQ-036 Write 0x400|0x3 (MEM_DEPTH_LOG2=10) data 0xA5A5A5A5, read addr 0x3 -> 0xA5A5A5A5 (alias); write control 0 to 0x3 -> complete pulses, value unchanged.
REQ-037 RST pulsed 2 cycles after a write accept -> no complete pulse, prior value at the address retained, readies high after reset.
